// File: rtl/ofm_res_write_sched_if.sv
// Bus bundle for ofm_res_write_sched.
// Carries the two producer streams (start/valid/data in, ready out), the shared
// memory write port, and the busy / frame_done status.
//   master : producer / memory side (drives start, valid, data)
//   slave  : the scheduler (drives ready, mem_wr_*, busy, frame_done)
interface ofm_res_write_sched_if #(
  parameter int WIDTH_DATA = 8,
  parameter int ADDR_W     = 9
);
  logic                  ofm_start;
  logic                  ofm_valid;
  logic                  ofm_data;
  logic                  ofm_ready;
  logic                  res_start;
  logic                  res_valid;
  logic [WIDTH_DATA-1:0] res_data;
  logic                  res_ready;
  logic                  mem_wr_en;
  logic                  mem_wr_sel;
  logic [ADDR_W-1:0]     mem_wr_addr;
  logic [WIDTH_DATA-1:0] mem_wr_data;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output ofm_start, ofm_valid, ofm_data, res_start, res_valid, res_data,
    input  ofm_ready, res_ready, mem_wr_en, mem_wr_sel, mem_wr_addr,
           mem_wr_data, busy, frame_done
  );

  modport slave (
    input  ofm_start, ofm_valid, ofm_data, res_start, res_valid, res_data,
    output ofm_ready, res_ready, mem_wr_en, mem_wr_sel, mem_wr_addr,
           mem_wr_data, busy, frame_done
  );
endinterface

// File: rtl/ofm_res_write_sched.sv
// Write scheduler sharing one OFM/residual memory write port between the OFM
// spike loader (stream 0) and the residual loader (stream 1).
// Each stream writes one DEPTH_F x DEPTH_F frame in raster order through its
// own address counter; round-robin arbitration on ties; frame_done pulses when
// both frames are written.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ofm_res_write_sched_if (streams, write port,
//                busy, frame_done)
module ofm_res_write_sched #(
  parameter int DEPTH_F    = 21,
  parameter int WIDTH_DATA = 8,
  parameter int ADDR_W     = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ofm_res_write_sched_if.slave  bus
);
  localparam int               N    = DEPTH_F * DEPTH_F;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} st_t;

  st_t               st_q  [2];
  st_t               st_d  [2];
  logic [ADDR_W-1:0] cnt_q [2];
  logic [ADDR_W-1:0] cnt_d [2];
  logic [1:0]        start, valid, req, gnt, fin, full_n;
  logic              last_q, last_d;   // 0 = ofm granted last, 1 = res
  logic              done_d, busy_d;

  logic                  wr_en_q, wr_sel_q, done_q, busy_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [WIDTH_DATA-1:0] wr_data_q;

  assign start = {bus.res_start, bus.ofm_start};
  assign valid = {bus.res_valid, bus.ofm_valid};

  always_comb begin
    for (int i = 0; i < 2; i++) req[i] = (st_q[i] == ACTIVE) && valid[i];
    // On a tie the stream that did not win last time gets the port.
    gnt[0] = req[0] & (~req[1] | last_q);
    gnt[1] = req[1] & (~req[0] | ~last_q);
    for (int i = 0; i < 2; i++) begin
      fin[i]    = gnt[i] && (cnt_q[i] == LAST);
      full_n[i] = (st_q[i] == FULL) || fin[i];
    end
    // Both frames complete after this edge: release both streams at once.
    done_d = &full_n;
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        IDLE:   if (start[i]) begin
                  st_d[i]  = ACTIVE;
                  cnt_d[i] = '0;
                end
        ACTIVE: if (fin[i])      st_d[i]  = done_d ? IDLE : FULL;
                else if (gnt[i]) cnt_d[i] = cnt_q[i] + 1'b1;
        FULL:   if (done_d)      st_d[i]  = IDLE;
        default:                 st_d[i]  = IDLE;
      endcase
    end
    last_d = gnt[0] ? 1'b0 : (gnt[1] ? 1'b1 : last_q);
    busy_d = (st_d[0] != IDLE) || (st_d[1] != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      last_q  <= last_d;
      wr_en_q <= |gnt;
      done_q  <= done_d;
      busy_q  <= busy_d;
      // Address/data/select hold their last values between writes.
      if (|gnt) begin
        wr_sel_q  <= gnt[1];
        wr_addr_q <= gnt[1] ? cnt_q[1] : cnt_q[0];
        wr_data_q <= gnt[1] ? bus.res_data
                            : {{(WIDTH_DATA-1){1'b0}}, bus.ofm_data};
      end
    end
  end

  assign bus.ofm_ready   = gnt[0];
  assign bus.res_ready   = gnt[1];
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_sel  = wr_sel_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_ofm_res_write_sched.sv
module tb_ofm_res_write_sched;
  localparam int DF = 21, N = 441, WD = 8, AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofm_res_write_sched_if #(.WIDTH_DATA(WD), .ADDR_W(AW)) ifc ();
  ofm_res_write_sched #(.DEPTH_F(DF), .WIDTH_DATA(WD), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  typedef struct {
    logic os, ov, od, rs, rv;
    logic [7:0] rd;
    logic eor, err, ewe, esel;
    logic [8:0] eaddr;
    logic [7:0] edata;
    logic ebusy;
  } vec_t;

  int n_chk = 0, n_err = 0;
  int wo, wr, nwr, n_done, ofm_idx, res_idx, cyc, ko, kr, bound;
  bit ofm_en, res_en, ofm_open, res_open, alt_chk, res_first, st_o, st_r, restarted;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_model();
    wo = 0; wr = 0; nwr = 0; n_done = 0; ofm_idx = 0; res_idx = 0; cyc = 0;
    ofm_en = 0; res_en = 0; ofm_open = 0; res_open = 0; alt_chk = 0;
    res_first = 0; st_o = 0; st_r = 0; restarted = 0; ko = 1; kr = 1;
  endtask

  // Called just after a rising edge: present this cycle's producer inputs.
  task automatic drive();
    ifc.ofm_start = st_o;
    ifc.res_start = st_r;
    st_o = 0; st_r = 0;
    ifc.ofm_valid = ofm_en && (cyc % ko == 0);
    ifc.ofm_data  = ~ofm_idx[0];
    ifc.res_valid = res_en && (cyc % kr == 0);
    ifc.res_data  = res_idx[7:0] ^ 8'h3C;
    cyc++;
  endtask

  // One cycle: sample and check mid-cycle, then drive the next cycle.
  task automatic step();
    bit hs_o, hs_r;
    @(negedge clk);
    if (!ofm_open) chk("ofm_ready_before_start", ifc.ofm_ready, 0);
    if (!res_open) chk("res_ready_before_start", ifc.res_ready, 0);
    if (ofm_idx >= N && ifc.ofm_valid) chk("ofm_ready_full", ifc.ofm_ready, 0);
    if (res_idx >= N && ifc.res_valid) chk("res_ready_full", ifc.res_ready, 0);
    if (ifc.ofm_start) ofm_open = 1;
    if (ifc.res_start) res_open = 1;
    hs_o = ifc.ofm_valid && ifc.ofm_ready;
    hs_r = ifc.res_valid && ifc.res_ready;
    if (ifc.mem_wr_en) begin
      if (alt_chk) chk("alt_sel", ifc.mem_wr_sel, nwr % 2);
      if (ifc.mem_wr_sel == 1'b0) begin
        chk("ofm_addr", ifc.mem_wr_addr, wo);
        chk("ofm_data", ifc.mem_wr_data, (wo % 2 == 0) ? 1 : 0);
        wo++;
      end else begin
        chk("res_addr", ifc.mem_wr_addr, wr);
        chk("res_data", ifc.mem_wr_data, (wr & 8'hFF) ^ 8'h3C);
        wr++;
        if (res_first && wr == N) chk("res_finishes_first", wo < N, 1);
      end
      nwr++;
    end
    if (ifc.frame_done) begin
      n_done++;
      chk("done_with_wr_en", ifc.mem_wr_en, 1);
      chk("done_busy_low", ifc.busy, 0);
      chk("done_after_last", (wo == N) && (wr == N), 1);
    end
    if (hs_o) ofm_idx++;
    if (hs_r) res_idx++;
    @(posedge clk); #1;
    drive();
  endtask

  task automatic chk_reset_outs();
    chk("rst_wr_en", ifc.mem_wr_en, 0);
    chk("rst_wr_sel", ifc.mem_wr_sel, 0);
    chk("rst_wr_addr", ifc.mem_wr_addr, 0);
    chk("rst_wr_data", ifc.mem_wr_data, 0);
    chk("rst_done", ifc.frame_done, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_ofm_ready", ifc.ofm_ready, 0);
    chk("rst_res_ready", ifc.res_ready, 0);
  endtask

  task automatic do_reset(input int nc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (nc) begin
      @(negedge clk);
      chk_reset_outs();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_model();
    drive();
  endtask

  vec_t tv [10];

  initial begin
    //          os ov od rs rv rd      or rr we sel addr  data   busy
    tv[0] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,9'd0,8'h00,1'b0};
    tv[1] = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,9'd0,8'h00,1'b0};
    tv[2] = '{1'b0,1'b1,1'b1,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,9'd0,8'h00,1'b1};
    tv[3] = '{1'b0,1'b1,1'b0,1'b1,1'b1,8'hA5, 1'b1,1'b0,1'b1,1'b0,9'd0,8'h01,1'b1};
    tv[4] = '{1'b0,1'b1,1'b1,1'b0,1'b1,8'h5A, 1'b0,1'b1,1'b1,1'b0,9'd1,8'h00,1'b1};
    tv[5] = '{1'b0,1'b1,1'b1,1'b0,1'b1,8'h33, 1'b1,1'b0,1'b1,1'b1,9'd0,8'h5A,1'b1};
    tv[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h44, 1'b0,1'b1,1'b1,1'b0,9'd2,8'h01,1'b1};
    tv[7] = '{1'b0,1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b1,9'd1,8'h44,1'b1};
    tv[8] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,9'd3,8'h00,1'b1};
    tv[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,9'd3,8'h00,1'b1};

    ifc.ofm_start = 0; ifc.ofm_valid = 0; ifc.ofm_data = 0;
    ifc.res_start = 0; ifc.res_valid = 0; ifc.res_data = '0;
    clr_model();

    // Power-on reset state.
    repeat (2) begin
      @(negedge clk);
      chk_reset_outs();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Short directed table: early data, start latency, ties, single requests.
    for (int i = 0; i < 10; i++) begin
      ifc.ofm_start = tv[i].os; ifc.ofm_valid = tv[i].ov; ifc.ofm_data = tv[i].od;
      ifc.res_start = tv[i].rs; ifc.res_valid = tv[i].rv; ifc.res_data = tv[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_ofm_ready", i), ifc.ofm_ready, tv[i].eor);
      chk($sformatf("v%0d_res_ready", i), ifc.res_ready, tv[i].err);
      chk($sformatf("v%0d_wr_en", i), ifc.mem_wr_en, tv[i].ewe);
      chk($sformatf("v%0d_wr_sel", i), ifc.mem_wr_sel, tv[i].esel);
      chk($sformatf("v%0d_wr_addr", i), ifc.mem_wr_addr, tv[i].eaddr);
      chk($sformatf("v%0d_wr_data", i), ifc.mem_wr_data, tv[i].edata);
      chk($sformatf("v%0d_busy", i), ifc.busy, tv[i].ebusy);
      chk($sformatf("v%0d_done", i), ifc.frame_done, 0);
      @(posedge clk); #1;
    end

    // OFM only, valid held high, with a redundant start at cnt 100.
    do_reset(2);
    ofm_en = 1; st_o = 1;
    step();
    bound = 0;
    while (ofm_idx < N && bound < 700) begin
      if (ofm_idx == 100 && !restarted) begin st_o = 1; restarted = 1; end
      step(); bound++;
    end
    repeat (5) step();
    chk("t1_ofm_writes", wo, N);
    chk("t1_res_writes", wr, 0);
    chk("t1_no_done", n_done, 0);
    chk("t1_busy_full", ifc.busy, 1);

    // Both streams, continuous valid, simultaneous start.
    do_reset(2);
    ofm_en = 1; res_en = 1; st_o = 1; st_r = 1; alt_chk = 1;
    step();
    bound = 0;
    while (n_done == 0 && bound < 1200) begin step(); bound++; end
    repeat (3) step();
    chk("t2_done_once", n_done, 1);
    chk("t2_total_writes", nwr, 2 * N);
    chk("t2_ofm_writes", wo, N);
    chk("t2_res_writes", wr, N);
    chk("t2_busy_after", ifc.busy, 0);

    // Unequal rates: OFM valid every 4th cycle.
    do_reset(2);
    ofm_en = 1; res_en = 1; ko = 4; kr = 1; st_o = 1; st_r = 1; res_first = 1;
    step();
    bound = 0;
    while (n_done == 0 && bound < 2500) begin step(); bound++; end
    repeat (3) step();
    chk("t3_done_once", n_done, 1);
    chk("t3_ofm_writes", wo, N);
    chk("t3_res_writes", wr, N);
    chk("t3_busy_after", ifc.busy, 0);

    // Reset in the middle of a residual frame, then restart.
    do_reset(2);
    res_en = 1; st_r = 1;
    step();
    bound = 0;
    while (res_idx < 200 && bound < 400) begin step(); bound++; end
    chk("t4_reached_200", res_idx, 200);
    ifc.res_valid = 1;
    do_reset(2);
    repeat (3) step();
    chk("t4_no_write_idle", nwr, 0);
    res_en = 1; st_r = 1;
    repeat (12) step();
    chk("t4_restart_writes", wr > 0, 1);
    chk("t4_no_done", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ofm_res_write_sched.md
# ofm_res_write_sched

Clocked write scheduler that shares the single write port of the output-feature-map / residual memory between two producers. The producers are the OFM spike loader (1-bit spikes) and the residual loader (WIDTH_DATA-bit values). Each producer streams one DEPTH_F×DEPTH_F frame in raster order. The block owns one address counter per stream, arbitrates round-robin between the two, and pulses `frame_done` once both frames are fully written.

## Interface
- DEPTH_F, 21, feature-map side length; frame length N = DEPTH_F*DEPTH_F (441)
- WIDTH_DATA, 8, residual width and memory write-data width
- ADDR_W, 9, address width; must satisfy 2^ADDR_W ≥ N

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ofm_start  in  1  one-cycle pulse that opens an OFM frame
- ofm_valid  in  1  OFM spike available
- ofm_data  in  1  spike value
- ofm_ready  out  1  OFM handshake accept
- res_start  in  1  one-cycle pulse that opens a residual frame
- res_valid  in  1  residual available
- res_data  in  WIDTH_DATA  residual value
- res_ready  out  1  residual handshake accept
- mem_wr_en  out  1  memory write strobe
- mem_wr_sel  out  1  bank select: 0 = OFM bank, 1 = residual bank
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  WIDTH_DATA  write data; OFM spike is zero-extended
- busy  out  1  at least one stream is ACTIVE or FULL
- frame_done  out  1  one-cycle pulse when both frames are complete

## Operation
- Each stream s ∈ {ofm, res} has its own state machine and counter cnt_s (ADDR_W bits). States are IDLE, ACTIVE and FULL.
  - IDLE → ACTIVE on s_start; cnt_s is cleared to 0.
  - ACTIVE → FULL on the accepted handshake where cnt_s == N-1.
  - FULL → IDLE only when both streams are FULL. That cycle asserts frame_done.
- s_start is ignored while the stream is in ACTIVE or FULL. The counter is not cleared.
- A stream requests when it is ACTIVE and s_valid = 1.
- Arbitration:
  - Only one request: that stream is granted.
  - Both request: the stream not granted last time is granted.
  - The `last` pointer resets to res, so ofm wins the first tie.
  - `last` updates only on an actual grant.
- s_ready = grant_s. Ready is combinational from valid, state and `last`. Producers must not make valid depend on ready.
- A stream in IDLE or FULL never gets ready, so its data is back-pressured. The counter never passes N-1, so there is no wrap-around.
- On a handshake:
  - registers mem_wr_en=1;
  - mem_wr_sel = stream id;
  - mem_wr_addr = cnt_s;
  - mem_wr_data = res_data, or {WIDTH_DATA-1 zeros, ofm_data};
  - cnt_s increments.
- No handshake: mem_wr_en=0. The other write outputs hold their last values.
- If one stream finishes first, it waits in FULL. The other stream then gets every grant.
- Simultaneous s_start on both streams is legal; both enter ACTIVE.
- If s_start and the final handshake of the other stream land in the same cycle, both take effect.

## Timing
- Reset (asynchronous assert, synchronous release):
  - mem_wr_en=0, mem_wr_sel=0, mem_wr_addr=0, mem_wr_data=0;
  - frame_done=0, busy=0;
  - ofm_ready=res_ready=0;
  - both states IDLE, both counters 0, `last`=res.
- Reset mid-frame discards partial progress. No write or frame_done is issued after reset.
- Start latency: s_start in cycle t → the stream is ACTIVE at t+1. ready can be high at t+1.
- Write latency: handshake in cycle t → mem_wr_en=1 with matching address and data in cycle t+1.
- Throughput: one write per cycle total. Two contending streams alternate 1:1.
- frame_done timing:
  - asserted for exactly the one cycle after the final handshake that brings the second stream to FULL;
  - concurrent with that handshake's mem_wr_en;
  - both streams are IDLE in that same cycle.
- busy is registered. It is high from t+1 after the first start until the frame_done cycle, and low in the frame_done cycle.

## Test plan
- OFM only: ofm_start, then 441 spikes alternating 1/0 with valid held high. Required:
  - 441 consecutive writes, sel=0, addr 0..440, data 0x01/0x00 alternating;
  - ofm_ready drops after the 441st write;
  - no frame_done.
- Both streams, continuous valid: starts in the same cycle. Required:
  - writes alternate sel 0,1,0,1…, ofm first;
  - each address 0..440 appears once per bank;
  - frame_done pulses once, one cycle after the 882nd handshake;
  - busy falls in that cycle.
- Unequal rates: res_valid high every cycle, ofm_valid every 4th cycle. Required:
  - residual completes first and idles in FULL with res_ready=0;
  - OFM finishes alone;
  - frame_done follows the last OFM write.
- Ignored start: ofm_start pulsed again at cnt_ofm=100. Required: addresses continue 101, 102…; no restart at 0.
- Reset mid-frame: rst_n low at cnt_res=200 for 2 cycles, then a new start. Required:
  - all outputs 0 during reset;
  - the next residual write uses address 0.
- Early data: ofm_valid=1 before ofm_start. Required: ofm_ready=0 and no writes until the cycle after the start.
